fetch_stage: RTL and testbench

Instruction-fetch front end of the pipelined MIPS datapath: owns the program counter, drives the byte address into `InstructionMemory`, and latches the returned word into the IF/ID pipeline register. It handles sequential PC+4 advance, taken-branch/jump redirect, hazard stall, and flush. It sits between `InstructionMemory` (combinational read, word index = `Address[8:2]`) and the decode stage.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/program_counter.sv | 46 ++++
 rtl/fetch_stage.sv | 91 +++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instruction;
    logic [31:0] pcplus4;
    logic        valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instruction: NOP_INSTR, pcplus4: 32'd0, valid: 1'b0};

endpackage

// File: rtl/program_counter.sv
// Program counter: register, next-PC priority mux and wrap to the instruction memory size.
module program_counter #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_branch_taken,
  input  logic [31:0] i_branch_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_plus4
);

  localparam logic [31:0] ImemBytes = 32'(IMEM_WORDS * 4);

  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;
  logic [31:0] w_pc_next;

  // Wrap is applied after the 32-bit add; redirect targets are forced word-aligned.
  assign w_pc_plus4 = (r_pc + 32'd4) % ImemBytes;
  assign w_target   = (i_branch_target & ~32'd3) % ImemBytes;

  always_comb begin
    w_pc_next = w_pc_plus4;
    if (i_branch_taken) begin
      w_pc_next = w_target;
    end else if (i_stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_next;
    end
  end

  assign o_pc       = r_pc;
  assign o_pc_plus4 = w_pc_plus4;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IF/ID pipeline register and optional perf counters.
// Define FETCH_PERF_EN to build FetchCount/StallCount; otherwise both read 0.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter int unsigned IMEM_WORDS = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] PCAddress,
  output logic [31:0] IF_ID_Instruction,
  output logic [31:0] IF_ID_PCPlus4,
  output logic        IF_ID_Valid,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  logic [31:0] w_pc_plus4;
  if_id_t      r_if_id;
  if_id_t      w_if_id_next;

  program_counter #(
    .RESET_PC  (RESET_PC),
    .IMEM_WORDS(IMEM_WORDS)
  ) u_program_counter (
    .i_clk          (Clk),
    .i_rst_n        (Reset),
    .i_stall        (Stall),
    .i_branch_taken (BranchTaken),
    .i_branch_target(BranchTarget),
    .o_pc           (PCAddress),
    .o_pc_plus4     (w_pc_plus4)
  );

  // No delay slot: a redirect squashes the word fetched alongside it.
  always_comb begin
    w_if_id_next = '{instruction: Instruction, pcplus4: w_pc_plus4, valid: 1'b1};
    if (BranchTaken || Flush) begin
      w_if_id_next = IF_ID_BUBBLE;
    end else if (Stall) begin
      w_if_id_next = r_if_id;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_if_id <= IF_ID_BUBBLE;
    end else begin
      r_if_id <= w_if_id_next;
    end
  end

  assign IF_ID_Instruction = r_if_id.instruction;
  assign IF_ID_PCPlus4     = r_if_id.pcplus4;
  assign IF_ID_Valid       = r_if_id.valid;

`ifdef FETCH_PERF_EN
  logic [31:0] r_fetch_count;
  logic [31:0] r_stall_count;
  logic        w_capture;

  assign w_capture = !BranchTaken && !Flush && !Stall;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_fetch_count <= 32'd0;
      r_stall_count <= 32'd0;
    end else begin
      if (w_capture) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
      if (Stall) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign FetchCount = r_fetch_count;
  assign StallCount = r_stall_count;
`else
  assign FetchCount = 32'd0;
  assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: integer-arithmetic reference model checked every cycle,
// plus directed steps with hand-computed expectations. Memory holds mem[i] = i*3.
module tb_fetch_stage;

  localparam int unsigned WORDS = 128;
  localparam longint unsigned BYTES = 512;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        Stall = 1'b0;
  logic        Flush = 1'b0;
  logic        BranchTaken = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic [31:0] Instruction;
  logic [31:0] PCAddress;
  logic [31:0] IF_ID_Instruction;
  logic [31:0] IF_ID_PCPlus4;
  logic        IF_ID_Valid;
  logic [31:0] FetchCount;
  logic [31:0] StallCount;

  logic [31:0] imem [WORDS];

  fetch_stage #(
    .RESET_PC  (32'd0),
    .IMEM_WORDS(WORDS)
  ) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Stall            (Stall),
    .Flush            (Flush),
    .BranchTaken      (BranchTaken),
    .BranchTarget     (BranchTarget),
    .Instruction      (Instruction),
    .PCAddress        (PCAddress),
    .IF_ID_Instruction(IF_ID_Instruction),
    .IF_ID_PCPlus4    (IF_ID_PCPlus4),
    .IF_ID_Valid      (IF_ID_Valid),
    .FetchCount       (FetchCount),
    .StallCount       (StallCount)
  );

  initial begin
    for (int i = 0; i < int'(WORDS); i++) imem[i] = 32'(i * 3);
  end

  assign Instruction = imem[PCAddress[8:2]];

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic run_chk = 1'b0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endfunction

  // Reference model: PC as a plain byte count, IF/ID as three fields.
  longint unsigned m_pc;
  logic [31:0]     m_instr;
  logic [31:0]     m_pcp4;
  logic            m_valid;
  logic [31:0]     m_fetch;
  logic [31:0]     m_stall;

  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      m_pc    <= 0;
      m_instr <= 32'd0;
      m_pcp4  <= 32'd0;
      m_valid <= 1'b0;
      m_fetch <= 32'd0;
      m_stall <= 32'd0;
    end else begin
      if (BranchTaken || Flush) begin
        m_instr <= 32'd0;
        m_pcp4  <= 32'd0;
        m_valid <= 1'b0;
      end else if (!Stall) begin
        m_instr <= 32'(((m_pc / 4) % WORDS) * 3);
        m_pcp4  <= 32'((m_pc + 4) % BYTES);
        m_valid <= 1'b1;
        m_fetch <= m_fetch + 32'd1;
      end
      if (Stall) m_stall <= m_stall + 32'd1;
      if (BranchTaken)
        m_pc <= (longint'(BranchTarget) - longint'(BranchTarget) % 4) % BYTES;
      else if (!Stall)
        m_pc <= (m_pc + 4) % BYTES;
    end
  end

  always @(negedge Clk) begin
    if (run_chk) begin
      chk("model_pc", PCAddress, 32'(m_pc));
      chk("model_instr", IF_ID_Instruction, m_instr);
      chk("model_pcplus4", IF_ID_PCPlus4, m_pcp4);
      chk("model_valid", {31'd0, IF_ID_Valid}, {31'd0, m_valid});
`ifdef FETCH_PERF_EN
      chk("model_fetchcount", FetchCount, m_fetch);
      chk("model_stallcount", StallCount, m_stall);
`else
      chk("model_fetchcount", FetchCount, 32'd0);
      chk("model_stallcount", StallCount, 32'd0);
`endif
    end
  end

  task automatic step(input logic st, input logic fl, input logic br, input logic [31:0] tg);
    Stall        = st;
    Flush        = fl;
    BranchTaken  = br;
    BranchTarget = tg;
    @(posedge Clk);
    #1;
  endtask

  task automatic chk_if(input string name, input logic [31:0] instr, input logic [31:0] pcp4,
                        input logic valid, input logic [31:0] pc);
    chk({name, "_instr"}, IF_ID_Instruction, instr);
    chk({name, "_pcplus4"}, IF_ID_PCPlus4, pcp4);
    chk({name, "_valid"}, {31'd0, IF_ID_Valid}, {31'd0, valid});
    chk({name, "_pc"}, PCAddress, pc);
  endtask

  initial begin
    repeat (2) @(posedge Clk);
    #1;
    chk_if("reset", 32'd0, 32'd0, 1'b0, 32'd0);
    chk("reset_fetchcount", FetchCount, 32'd0);
    chk("reset_stallcount", StallCount, 32'd0);

    run_chk = 1'b1;
    Reset   = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("seq0", 32'd0, 32'd4, 1'b1, 32'd4);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("seq1", 32'd3, 32'd8, 1'b1, 32'd8);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("seq2", 32'd6, 32'd12, 1'b1, 32'd12);
`ifdef FETCH_PERF_EN
    chk("fetchcount3", FetchCount, 32'd3);
`endif

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'd0);
      chk_if("stall_hold", 32'd6, 32'd12, 1'b1, 32'd12);
    end
`ifdef FETCH_PERF_EN
    chk("stallcount3", StallCount, 32'd3);
`endif
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("stall_release", 32'd9, 32'd16, 1'b1, 32'd16);

    step(1'b0, 1'b0, 1'b1, 32'd40);
    chk_if("branch_bubble", 32'd0, 32'd0, 1'b0, 32'd40);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("branch_target", 32'd30, 32'd44, 1'b1, 32'd44);

    step(1'b1, 1'b1, 1'b0, 32'd0);
    chk_if("flush_stall", 32'd0, 32'd0, 1'b0, 32'd44);

    step(1'b0, 1'b0, 1'b1, 32'd43);
    chk_if("branch_unaligned", 32'd0, 32'd0, 1'b0, 32'd40);

    step(1'b1, 1'b0, 1'b1, 32'd100);
    chk_if("stall_branch", 32'd0, 32'd0, 1'b0, 32'd100);

    step(1'b0, 1'b0, 1'b1, 32'd504);
    chk("to_504_pc", PCAddress, 32'd504);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("word126", 32'd378, 32'd508, 1'b1, 32'd508);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("wrap_last", 32'd381, 32'd0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("wrap_first", 32'd0, 32'd4, 1'b1, 32'd4);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
    chk("branch_huge_pc", PCAddress, 32'd508);
    step(1'b1, 1'b0, 1'b0, 32'd0);
    chk_if("stall_held_bubble", 32'd0, 32'd0, 1'b0, 32'd508);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("after_held_bubble", 32'd381, 32'd0, 1'b1, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("pre_async", 32'd0, 32'd4, 1'b1, 32'd4);

    // Assert reset mid-cycle during a stall, well away from any clock edge.
    Stall = 1'b1;
    #2;
    Reset = 1'b0;
    #1;
    chk_if("async_reset", 32'd0, 32'd0, 1'b0, 32'd0);
    chk("async_fetchcount", FetchCount, 32'd0);
    chk("async_stallcount", StallCount, 32'd0);

    Stall = 1'b0;
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 32'd0);
    chk_if("post_reset", 32'd0, 32'd4, 1'b1, 32'd4);

    @(negedge Clk);
    #1;
    run_chk = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
